// File: rtl/shot_anim_if.sv
// Shot animation scheduler bus.
// Groups the game-side shot handshake and the renderer/status outputs.
//   shot_valid/shot_ready : valid/ready handshake. A shot result transfers on a
//                           rising clk edge where shot_valid && shot_ready are
//                           both high. shot_made is qualified by shot_valid.
//                           The master may hold or drop shot_valid at will.
//                           shot_ready depends only on the queue occupancy.
//   abort                 : drop the current animation and flush the queue.
//   run_make/run_miss     : renderer run enables (at most one high).
//   anim_frame            : current frame index.
//   busy/done/pending     : status (busy, one-cycle completion pulse, queue depth).
//   make_count/miss_count : saturating tallies of completed animations.
// Modports: master = game logic / testbench, slave = scheduler.
interface shot_anim_if;
  logic       shot_valid;
  logic       shot_made;
  logic       shot_ready;
  logic       abort;
  logic       run_make;
  logic       run_miss;
  logic [1:0] anim_frame;
  logic       busy;
  logic       done;
  logic [1:0] pending;
  logic [7:0] make_count;
  logic [7:0] miss_count;

  modport master (
    output shot_valid, shot_made, abort,
    input  shot_ready, run_make, run_miss, anim_frame, busy, done, pending,
           make_count, miss_count
  );

  modport slave (
    input  shot_valid, shot_made, abort,
    output shot_ready, run_make, run_miss, anim_frame, busy, done, pending,
           make_count, miss_count
  );
endinterface

// File: rtl/shot_anim_scheduler.sv
// Shot animation scheduler.
// Queues shot results (2-entry FIFO), plays one make/miss animation at a time,
// times its frames, holds the final frame, then pulses done and updates the
// saturating make/miss tallies.
// Ports:
//   clk       : system clock, posedge
//   rst_n     : synchronous active-low reset
//   bus       : shot_anim_if.slave (handshake, renderer enables, status)
//   state_dbg : current FSM state (0 IDLE, 1 PLAY, 2 HOLD, 3 DONE)
module shot_anim_scheduler #(
  parameter int FRAME_TICKS = 10_000_000,
  parameter int NUM_FRAMES  = 4,
  parameter int HOLD_TICKS  = 25_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  shot_anim_if.slave   bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

  // One tick counter serves both the frame timer and the hold timer.
  localparam int TMAX = (FRAME_TICKS > HOLD_TICKS) ? FRAME_TICKS : HOLD_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] FT_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [TW-1:0] HT_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [1:0]    NF_LAST = 2'(NUM_FRAMES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    frame_q, frame_d;
  logic          kind_q, kind_d;      // 1 = make animation in progress
  logic [1:0]    fifo_q, fifo_d;      // bit 0 is the head
  logic [1:0]    cnt_q, cnt_d;
  logic          run_make_q, run_make_d;
  logic          run_miss_q, run_miss_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    make_cnt_q, make_cnt_d;
  logic [7:0]    miss_cnt_q, miss_cnt_d;
  logic          push, pop;

  always_comb begin
    push       = bus.shot_valid && (cnt_q != 2'd2) && !bus.abort;
    pop        = (state_q == IDLE) && (cnt_q != 2'd0) && !bus.abort;
    state_d    = state_q;
    tick_d     = tick_q;
    frame_d    = frame_q;
    kind_d     = kind_q;
    fifo_d     = fifo_q;
    cnt_d      = cnt_q;
    run_make_d = run_make_q;
    run_miss_d = run_miss_q;
    done_d     = 1'b0;
    make_cnt_d = make_cnt_q;
    miss_cnt_d = miss_cnt_q;

    // Pop first, then push into the slot left free: a simultaneous
    // push/pop keeps the count and preserves order.
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_d - 2'd1;
    end
    if (push) begin
      fifo_d[cnt_d[0]] = bus.shot_made;
      cnt_d            = cnt_d + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = PLAY;
          kind_d     = fifo_q[0];
          run_make_d = fifo_q[0];
          run_miss_d = !fifo_q[0];
          frame_d    = 2'd0;
          tick_d     = '0;
        end
      end
      PLAY: begin
        if (tick_q == FT_LAST) begin
          tick_d = '0;
          if (frame_q == NF_LAST) state_d = HOLD;
          else                    frame_d = frame_q + 2'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      HOLD: begin
        if (tick_q == HT_LAST) begin
          state_d    = DONE;
          tick_d     = '0;
          frame_d    = 2'd0;
          run_make_d = 1'b0;
          run_miss_d = 1'b0;
          done_d     = 1'b1;
          if (kind_q) make_cnt_d = (make_cnt_q != 8'hFF) ? make_cnt_q + 8'd1 : make_cnt_q;
          else        miss_cnt_d = (miss_cnt_q != 8'hFF) ? miss_cnt_q + 8'd1 : miss_cnt_q;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;  // DONE lasts one cycle
    endcase

    // Abort wins over everything, including a completion on the same edge.
    if (bus.abort) begin
      state_d    = IDLE;
      cnt_d      = 2'd0;
      tick_d     = '0;
      frame_d    = 2'd0;
      run_make_d = 1'b0;
      run_miss_d = 1'b0;
      done_d     = 1'b0;
      make_cnt_d = make_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      frame_q    <= 2'd0;
      kind_q     <= 1'b0;
      fifo_q     <= 2'b00;
      cnt_q      <= 2'd0;
      run_make_q <= 1'b0;
      run_miss_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      make_cnt_q <= 8'd0;
      miss_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      kind_q     <= kind_d;
      fifo_q     <= fifo_d;
      cnt_q      <= cnt_d;
      run_make_q <= run_make_d;
      run_miss_q <= run_miss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      make_cnt_q <= make_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.shot_ready = (cnt_q != 2'd2);
  assign bus.run_make   = run_make_q;
  assign bus.run_miss   = run_miss_q;
  assign bus.anim_frame = frame_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pending    = cnt_q;
  assign bus.make_count = make_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_shot_anim_scheduler.sv
// Directed testbench for shot_anim_scheduler with FRAME_TICKS=4,
// NUM_FRAMES=4, HOLD_TICKS=3. A shot accepted at edge E plays from E+1,
// holds E+17..E+19 and pulses done at E+20.
module tb_shot_anim_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  shot_anim_if bus ();

  shot_anim_scheduler #(.FRAME_TICKS(4), .NUM_FRAMES(4), .HOLD_TICKS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.shot_valid = 1'b0;
    bus.shot_made  = 1'b0;
    bus.abort      = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b1;
    bus.abort      = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.run_make !== 1'b0 || bus.run_miss !== 1'b0 || bus.anim_frame !== 2'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pending !== 2'd0 ||
        bus.make_count !== 8'd0 || bus.miss_count !== 8'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: run_make=%b run_miss=%b frame=%0d busy=%b done=%b pending=%0d make=%0d miss=%0d state=%0d, required all zero",
               bus.run_make, bus.run_miss, bus.anim_frame, bus.busy, bus.done, bus.pending,
               bus.make_count, bus.miss_count, state_dbg);
    end
    checks++;
    if (bus.shot_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", bus.shot_ready);
    end
    bus.shot_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.pending !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b pending=%0d required 0/0", bus.busy, bus.pending);
    end
  endtask

  task automatic test_single_make();
    logic [1:0] exp_frame;
    do_reset();
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b1;
    step();  // edge E
    bus.shot_valid = 1'b0;
    checks++;
    if (bus.pending !== 2'd1 || bus.busy !== 1'b0 || bus.run_make !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: pending=%0d busy=%b run_make=%b required 1/0/0",
               bus.pending, bus.busy, bus.run_make);
    end
    for (int k = 1; k <= 19; k++) begin
      step();
      exp_frame = (k <= 16) ? 2'((k - 1) / 4) : 2'd3;
      checks++;
      if (bus.run_make !== 1'b1 || bus.run_miss !== 1'b0 || bus.anim_frame !== exp_frame ||
          bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.pending !== 2'd0) begin
        errors++;
        $display("FAIL single_play E+%0d: run_make=%b run_miss=%b frame=%0d done=%b busy=%b pending=%0d required 1/0/%0d/0/1/0",
                 k, bus.run_make, bus.run_miss, bus.anim_frame, bus.done, bus.busy, bus.pending, exp_frame);
      end
    end
    step();  // E+20
    checks++;
    if (bus.done !== 1'b1 || bus.run_make !== 1'b0 || bus.anim_frame !== 2'd0 ||
        bus.make_count !== 8'd1 || bus.miss_count !== 8'd0) begin
      errors++;
      $display("FAIL single_done: done=%b run_make=%b frame=%0d make=%0d miss=%0d required 1/0/0/1/0",
               bus.done, bus.run_make, bus.anim_frame, bus.make_count, bus.miss_count);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: done=%b busy=%b required 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b0;
    step();  // E: miss pushed
    bus.shot_made  = 1'b1;
    step();  // E+1: miss popped, make pushed
    bus.shot_valid = 1'b0;
    checks++;
    if (bus.pending !== 2'd1) begin
      errors++;
      $display("FAIL b2b_pending: got %0d required 1", bus.pending);
    end
    for (int k = 1; k <= 19; k++) begin
      if (k > 1) step();
      checks++;
      if (bus.run_miss !== 1'b1 || bus.run_make !== 1'b0) begin
        errors++;
        $display("FAIL b2b_miss_run E+%0d: run_miss=%b run_make=%b required 1/0", k, bus.run_miss, bus.run_make);
      end
    end
    step();  // E+20
    checks++;
    if (bus.done !== 1'b1 || bus.miss_count !== 8'd1 || bus.run_miss !== 1'b0 || bus.run_make !== 1'b0) begin
      errors++;
      $display("FAIL b2b_miss_done: done=%b miss=%0d runs=%b%b required 1/1/00",
               bus.done, bus.miss_count, bus.run_miss, bus.run_make);
    end
    step();  // E+21: IDLE
    checks++;
    if (bus.run_miss !== 1'b0 || bus.run_make !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: runs=%b%b done=%b busy=%b required 00/0/0",
               bus.run_miss, bus.run_make, bus.done, bus.busy);
    end
    for (int k = 1; k <= 19; k++) begin
      step();
      checks++;
      if (bus.run_make !== 1'b1 || bus.run_miss !== 1'b0) begin
        errors++;
        $display("FAIL b2b_make_run %0d: run_make=%b run_miss=%b required 1/0", k, bus.run_make, bus.run_miss);
      end
    end
    step();
    checks++;
    if (bus.done !== 1'b1 || bus.make_count !== 8'd1 || bus.miss_count !== 8'd1) begin
      errors++;
      $display("FAIL b2b_make_done: done=%b make=%0d miss=%0d required 1/1/1",
               bus.done, bus.make_count, bus.miss_count);
    end
  endtask

  task automatic test_queue_full();
    int dones;
    do_reset();
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b1;
    step();  // E
    bus.shot_valid = 1'b0;
    step();
    step();  // PLAY, queue empty
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b0;
    step();  // miss pushed
    bus.shot_made  = 1'b1;
    step();  // make pushed
    checks++;
    if (bus.shot_ready !== 1'b0 || bus.pending !== 2'd2) begin
      errors++;
      $display("FAIL full_ready: ready=%b pending=%0d required 0/2", bus.shot_ready, bus.pending);
    end
    bus.shot_made = 1'b0;
    step();  // third offer (miss) dropped
    bus.shot_valid = 1'b0;
    checks++;
    if (bus.pending !== 2'd2) begin
      errors++;
      $display("FAIL full_drop: pending=%0d required 2", bus.pending);
    end
    dones = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 3) begin
      errors++;
      $display("FAIL full_dones: got %0d required 3", dones);
    end
    checks++;
    if (bus.make_count !== 8'd2 || bus.miss_count !== 8'd1 || bus.busy !== 1'b0 || bus.pending !== 2'd0) begin
      errors++;
      $display("FAIL full_counts: make=%0d miss=%0d busy=%b pending=%0d required 2/1/0/0",
               bus.make_count, bus.miss_count, bus.busy, bus.pending);
    end
  endtask

  task automatic test_abort_hold();
    do_reset();
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b1;
    step();  // E
    bus.shot_valid = 1'b0;
    step();  // E+1
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b0;
    step();  // E+2
    step();  // E+3
    bus.shot_valid = 1'b0;
    for (int c = 0; c < 15; c++) step();  // E+18
    checks++;
    if (state_dbg !== 2'd2 || bus.pending !== 2'd2 || bus.run_make !== 1'b1 || bus.anim_frame !== 2'd3) begin
      errors++;
      $display("FAIL abort_pre: state=%0d pending=%0d run_make=%b frame=%0d required 2/2/1/3",
               state_dbg, bus.pending, bus.run_make, bus.anim_frame);
    end
    bus.abort      = 1'b1;
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b1;
    step();  // E+19
    bus.abort      = 1'b0;
    bus.shot_valid = 1'b0;
    checks++;
    if (state_dbg !== 2'd0 || bus.busy !== 1'b0 || bus.pending !== 2'd0 || bus.run_make !== 1'b0 ||
        bus.run_miss !== 1'b0 || bus.anim_frame !== 2'd0 || bus.done !== 1'b0 || bus.shot_ready !== 1'b1 ||
        bus.make_count !== 8'd0 || bus.miss_count !== 8'd0) begin
      errors++;
      $display("FAIL abort_post: state=%0d busy=%b pending=%0d runs=%b%b frame=%0d done=%b ready=%b make=%0d miss=%0d required 0/0/0/00/0/0/1/0/0",
               state_dbg, bus.busy, bus.pending, bus.run_make, bus.run_miss, bus.anim_frame,
               bus.done, bus.shot_ready, bus.make_count, bus.miss_count);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet %0d: done=%b busy=%b required 0/0", c, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b1;
    step();  // E
    bus.shot_valid = 1'b0;
    for (int c = 0; c < 21; c++) step();
    checks++;
    if (bus.make_count !== 8'd1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: make=%0d busy=%b required 1/0", bus.make_count, bus.busy);
    end
    bus.shot_valid = 1'b1;
    bus.shot_made  = 1'b0;
    step();  // E2: miss pushed
    bus.shot_made  = 1'b1;
    step();  // E2+1: miss plays, make queued
    bus.shot_valid = 1'b0;
    for (int c = 0; c < 9; c++) step();  // E2+10
    checks++;
    if (bus.anim_frame !== 2'd2 || bus.run_miss !== 1'b1 || bus.pending !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_frame: frame=%0d run_miss=%b pending=%0d required 2/1/1",
               bus.anim_frame, bus.run_miss, bus.pending);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.run_make !== 1'b0 || bus.run_miss !== 1'b0 || bus.anim_frame !== 2'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.pending !== 2'd0 || bus.make_count !== 8'd0 || bus.miss_count !== 8'd0 ||
        bus.shot_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post: runs=%b%b frame=%0d busy=%b done=%b pending=%0d make=%0d miss=%0d ready=%b required 00/0/0/0/0/0/0/1",
               bus.run_make, bus.run_miss, bus.anim_frame, bus.busy, bus.done, bus.pending,
               bus.make_count, bus.miss_count, bus.shot_ready);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_saturate();
    int pushes;
    int dones;
    do_reset();
    pushes = 0;
    dones  = 0;
    bus.shot_made = 1'b1;
    for (int c = 0; c < 8000 && dones < 256; c++) begin
      bus.shot_valid = (pushes < 256);
      if (bus.shot_valid && bus.shot_ready) pushes++;
      step();
      if (bus.done === 1'b1) dones++;
    end
    bus.shot_valid = 1'b0;
    checks++;
    if (dones !== 256) begin
      errors++;
      $display("FAIL sat_dones: got %0d required 256 within cycle budget", dones);
    end
    checks++;
    if (bus.make_count !== 8'd255 || bus.miss_count !== 8'd0) begin
      errors++;
      $display("FAIL sat_counts: make=%0d miss=%0d required 255/0", bus.make_count, bus.miss_count);
    end
  endtask

  initial begin
    bus.shot_valid = 1'b0;
    bus.shot_made  = 1'b0;
    bus.abort      = 1'b0;
    test_reset();
    test_single_make();
    test_back_to_back();
    test_queue_full();
    test_abort_hold();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
